// File: rtl/pos_packet_framer.sv
// pos_packet_framer: frames a snapshot of object position/orientation into a
// byte packet for a downstream UART byte transmitter (valid/ready handshake).
//
// Optional feature macro: PKT_CHECKSUM_EN
//   defined   -> 11-byte packet, last byte is the mod-256 sum of bytes 2..9
//   undefined -> 10-byte packet ending at ay[7:0], no checksum logic
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   tx_int                      one-cycle send request
//   centre_pos_x, centre_pos_y  object centre (12 bit)
//   angle_x, angle_y            orientation vector (10 bit)
//   chieu_xoay                  rotation direction flag
//   tx_data, tx_valid, tx_ready byte stream to the transmitter
//   busy                        a packet is in progress
//   drop_cnt                    saturating count of requests dropped while busy
module pos_packet_framer #(
  parameter logic [7:0] HEADER0 = 8'hAA,
  parameter logic [7:0] HEADER1 = 8'h55
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_int,
  input  logic [11:0] centre_pos_x,
  input  logic [11:0] centre_pos_y,
  input  logic [9:0]  angle_x,
  input  logic [9:0]  angle_y,
  input  logic        chieu_xoay,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

`ifdef PKT_CHECKSUM_EN
  localparam int unsigned NUM_BYTES = 11;
`else
  localparam int unsigned NUM_BYTES = 10;
`endif
  localparam int unsigned IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t state, state_next;

  logic [IDX_W-1:0] idx, idx_next;
  logic [11:0]      snap_x, snap_y;
  logic [9:0]       snap_ax, snap_ay;
  logic             snap_cx;
  logic [7:0]       tx_data_next;
  logic             tx_valid_next;
  logic             busy_next;
  logic             load_c;
  logic             xfer_c;
  logic [IDX_W-1:0] idx_inc_c;
  logic [7:0]       next_byte_c;

  assign xfer_c    = tx_valid & tx_ready;
  assign idx_inc_c = idx + IDX_W'(1);

  // Payload bytes 2..9 formed from the snapshot
  logic [7:0] b2_c, b3_c, b4_c, b5_c, b6_c, b7_c, b8_c, b9_c;
  assign b2_c = {4'b0000, snap_x[11:8]};
  assign b3_c = snap_x[7:0];
  assign b4_c = {4'b0000, snap_y[11:8]};
  assign b5_c = snap_y[7:0];
  assign b6_c = {snap_cx, 5'b00000, snap_ax[9:8]};
  assign b7_c = snap_ax[7:0];
  assign b8_c = {6'b000000, snap_ay[9:8]};
  assign b9_c = snap_ay[7:0];

`ifdef PKT_CHECKSUM_EN
  // Snapshot is frozen for the whole packet, so the sum settles long before byte 10
  logic [7:0] csum_c;
  assign csum_c = 8'(b2_c + b3_c + b4_c + b5_c + b6_c + b7_c + b8_c + b9_c);
`endif

  // Byte to present after the current one transfers
  always_comb begin
    next_byte_c = 8'h00;
    case (idx_inc_c)
      4'd1:    next_byte_c = HEADER1;
      4'd2:    next_byte_c = b2_c;
      4'd3:    next_byte_c = b3_c;
      4'd4:    next_byte_c = b4_c;
      4'd5:    next_byte_c = b5_c;
      4'd6:    next_byte_c = b6_c;
      4'd7:    next_byte_c = b7_c;
      4'd8:    next_byte_c = b8_c;
      4'd9:    next_byte_c = b9_c;
`ifdef PKT_CHECKSUM_EN
      4'd10:   next_byte_c = csum_c;
`endif
      default: next_byte_c = 8'h00;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tx_int) state_next = SEND;
      SEND:    if (xfer_c && (idx == LAST_IDX)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath next values (registered below)
  always_comb begin
    load_c        = 1'b0;
    idx_next      = idx;
    tx_data_next  = tx_data;
    tx_valid_next = tx_valid;
    case (state)
      IDLE: begin
        tx_valid_next = 1'b0;
        tx_data_next  = 8'h00;
        if (tx_int) begin
          load_c        = 1'b1;
          idx_next      = '0;
          tx_valid_next = 1'b1;
          tx_data_next  = HEADER0;
        end
      end
      SEND: begin
        if (xfer_c) begin
          if (idx == LAST_IDX) begin
            idx_next      = '0;
            tx_valid_next = 1'b0;
            tx_data_next  = 8'h00;
          end else begin
            idx_next      = idx_inc_c;
            tx_valid_next = 1'b1;
            tx_data_next  = next_byte_c;
          end
        end
      end
      default: begin
        idx_next      = '0;
        tx_valid_next = 1'b0;
        tx_data_next  = 8'h00;
      end
    endcase
    busy_next = (state_next == SEND);
  end

  // Registered outputs, byte index and snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      snap_x   <= '0;
      snap_y   <= '0;
      snap_ax  <= '0;
      snap_ay  <= '0;
      snap_cx  <= 1'b0;
    end else begin
      idx      <= idx_next;
      tx_data  <= tx_data_next;
      tx_valid <= tx_valid_next;
      busy     <= busy_next;
      if (load_c) begin
        snap_x  <= centre_pos_x;
        snap_y  <= centre_pos_y;
        snap_ax <= angle_x;
        snap_ay <= angle_y;
        snap_cx <= chieu_xoay;
      end
    end
  end

  // Requests arriving mid-packet (including the last-byte cycle) are counted, not queued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                            drop_cnt <= 8'h00;
    else if ((state == SEND) && tx_int && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
  end

endmodule
